// File: rtl/redmule_mx_pkg.sv
// Shared definitions for the MX encoder arbiter slice.
//   arb_state_e       : arbiter FSM states
//   MX_ELEM_W         : width of one encoded MX element
//   MX_EXP_W          : width of the E8M0 shared exponent
//   groups_per_block(): input beats that make up one MX block
package redmule_mx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned MX_ELEM_W = 8;
    localparam int unsigned MX_EXP_W  = 8;

    // One MX block holds DATA_W/MX_ELEM_W elements and each input beat
    // supplies num_lanes of them.
    function automatic int unsigned groups_per_block(input int unsigned data_w,
                                                     input int unsigned num_lanes);
        return data_w / MX_ELEM_W / num_lanes;
    endfunction

endpackage

// File: rtl/redmule_mx_tag_fifo.sv
// Small FIFO of requester IDs for blocks that are inside the encoder.
// The head is read combinationally so the output join adds no latency.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   push_i, push_data_i : write one ID
//   pop_i               : drop the head entry
//   head_o              : current head ID (valid when !empty_o)
//   full_o, empty_o     : occupancy flags from the registered count
module redmule_mx_tag_fifo #(
    parameter int unsigned ID_W  = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [ID_W-1:0] push_data_i,
    input  logic            pop_i,
    output logic [ID_W-1:0] head_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_reg == CNT_W'(DEPTH));
    assign empty_o = (count_reg == '0);
    assign head_o  = mem[rd_ptr_reg];

    // A push into a full FIFO is only safe when the head leaves in the
    // same cycle; the write then lands in the slot being vacated.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/redmule_mx_enc_arbiter.sv
// Shares one MX encoder between NUM_REQ FP16 producers. A requester owns
// the encoder input for a whole MX block (GROUPS_PER_BLOCK beats); grants
// rotate round-robin. The requester ID of every granted block is queued
// and rejoined with the encoder's value/exponent outputs.
//   clk_i, rst_i                : clock, asynchronous active-high reset
//   req_valid_i/ready_o/data_i  : per-requester FP16 beat streams
//   enc_fp16_*                  : muxed beat stream into the encoder
//   enc_val_*, enc_exp_*        : encoder value and exponent outputs
//   mx_valid_o/ready_i          : joined output handshake
//   mx_val_data_o/exp_data_o/id_o : encoded block, exponent, source ID
module redmule_mx_enc_arbiter
    import redmule_mx_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_LANES = 8,
    parameter int unsigned BITW      = 16,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned TAG_DEPTH = 2,
    localparam int unsigned GROUPS_PER_BLOCK = groups_per_block(DATA_W, NUM_LANES),
    localparam int unsigned ID_W             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*NUM_LANES*BITW-1:0] req_data_i,
    output logic                           enc_fp16_valid_o,
    input  logic                           enc_fp16_ready_i,
    output logic [NUM_LANES*BITW-1:0]      enc_fp16_data_o,
    input  logic                           enc_val_valid_i,
    output logic                           enc_val_ready_o,
    input  logic [DATA_W-1:0]              enc_val_data_i,
    input  logic                           enc_exp_valid_i,
    output logic                           enc_exp_ready_o,
    input  logic [MX_EXP_W-1:0]            enc_exp_data_i,
    output logic                           mx_valid_o,
    input  logic                           mx_ready_i,
    output logic [DATA_W-1:0]              mx_val_data_o,
    output logic [MX_EXP_W-1:0]            mx_exp_data_o,
    output logic [ID_W-1:0]                mx_id_o
);

    localparam int unsigned BEAT_W = NUM_LANES * BITW;
    localparam int unsigned CNT_W  = (GROUPS_PER_BLOCK > 1) ? $clog2(GROUPS_PER_BLOCK) : 1;

    arb_state_e        state_reg;
    logic [ID_W-1:0]   grant_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [CNT_W-1:0]  beat_cnt_reg;

    logic [BEAT_W-1:0] req_beat [NUM_REQ];
    logic              busy;
    logic              in_hs;
    logic              last_beat;
    logic              out_avail;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W:0]     pick_cand;
    logic [ID_W-1:0]   rr_next;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_beat[gi]    = req_data_i[gi*BEAT_W +: BEAT_W];
        assign req_ready_o[gi] = busy && (grant_reg == ID_W'(gi)) && enc_fp16_ready_i;
    end

    assign busy             = (state_reg == BUSY);
    assign enc_fp16_valid_o = busy && req_valid_i[grant_reg];
    assign enc_fp16_data_o  = req_beat[grant_reg];
    assign in_hs            = enc_fp16_valid_o && enc_fp16_ready_i;
    assign last_beat        = in_hs && (beat_cnt_reg == CNT_W'(GROUPS_PER_BLOCK - 1));
    assign rr_next          = (grant_reg == ID_W'(NUM_REQ - 1)) ? '0 : grant_reg + ID_W'(1);

    // Round-robin search starting at rr_ptr_reg; the candidate index is
    // kept one bit wider so the wrap can be done by a single subtract.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = rr_ptr_reg;
        pick_cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pick_cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(i);
            if (pick_cand >= (ID_W+1)'(NUM_REQ)) begin
                pick_cand = pick_cand - (ID_W+1)'(NUM_REQ);
            end
            if (!pick_found && req_valid_i[pick_cand[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = pick_cand[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A grant needs a free tag slot so the block's ID can
                    // always be recorded when its last beat goes in.
                    if (pick_found && !fifo_full) begin
                        grant_reg    <= pick_id;
                        beat_cnt_reg <= '0;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    // The grant is held until the block is complete, even
                    // while the owner stalls.
                    if (last_beat) begin
                        rr_ptr_reg   <= rr_next;
                        beat_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end else if (in_hs) begin
                        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    redmule_mx_tag_fifo #(
        .ID_W  (ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (last_beat),
        .push_data_i (grant_reg),
        .pop_i       (mx_valid_o && mx_ready_i),
        .head_o      (mx_id_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // The encoder expects its value and exponent readies together, so both
    // are released only once the joined output actually transfers.
    assign out_avail       = enc_val_valid_i && enc_exp_valid_i && !fifo_empty;
    assign mx_valid_o      = out_avail;
    assign enc_val_ready_o = mx_ready_i && out_avail;
    assign enc_exp_ready_o = mx_ready_i && out_avail;
    assign mx_val_data_o   = enc_val_data_i;
    assign mx_exp_data_o   = enc_exp_data_i;

    // Encoder output without a queued ID means a block nobody was granted.
    a_no_orphan_output: assert property (@(posedge clk_i) disable iff (rst_i)
        !((enc_val_valid_i || enc_exp_valid_i) && fifo_empty));

endmodule
